mem_port_arbiter: RTL

Shares one single-port memory between the CPU instruction bus (Iw*) and data bus (Dw*). The block sits between the CPU and a synchronous memory with fixed read latency. It grants one requester at a time and sequences the memory command and the wait for read data. It returns a per-port ready pulse and a combined stall indication, so the pipeline or multicycle control can freeze while a port waits.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_port_arbiter_priority_sel.sv | 24 ++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } arb_state_e;

  typedef logic [1:0] grant_t;

  localparam grant_t GNT_NONE = 2'b00;
  localparam grant_t GNT_I    = 2'b01;
  localparam grant_t GNT_D    = 2'b10;

  // A port requests when either enable is high.
  function automatic logic is_req(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU-side instruction/data ports plus the memory-side command bus.
interface mem_port_arbiter_if;

  logic        iIReadEnable;
  logic        iIWriteEnable;
  logic [3:0]  iIByteEnable;
  logic [31:0] iIAddress;
  logic [31:0] iIWriteData;
  logic [31:0] oIReadData;
  logic        oIReady;

  logic        iDReadEnable;
  logic        iDWriteEnable;
  logic [3:0]  iDByteEnable;
  logic [31:0] iDAddress;
  logic [31:0] iDWriteData;
  logic [31:0] oDReadData;
  logic        oDReady;

  logic        oMReadEnable;
  logic        oMWriteEnable;
  logic [3:0]  oMByteEnable;
  logic [31:0] oMAddress;
  logic [31:0] oMWriteData;
  logic [31:0] iMReadData;

  logic        oStall;
  logic [1:0]  oGrant;

  // Arbiter view.
  modport slave (
    input  iIReadEnable, iIWriteEnable, iIByteEnable, iIAddress, iIWriteData,
    output oIReadData, oIReady,
    input  iDReadEnable, iDWriteEnable, iDByteEnable, iDAddress, iDWriteData,
    output oDReadData, oDReady,
    output oMReadEnable, oMWriteEnable, oMByteEnable, oMAddress, oMWriteData,
    input  iMReadData,
    output oStall, oGrant
  );

  // CPU and memory view.
  modport master (
    output iIReadEnable, iIWriteEnable, iIByteEnable, iIAddress, iIWriteData,
    input  oIReadData, oIReady,
    output iDReadEnable, iDWriteEnable, iDByteEnable, iDAddress, iDWriteData,
    input  oDReadData, oDReady,
    input  oMReadEnable, oMWriteEnable, oMByteEnable, oMAddress, oMWriteData,
    output iMReadData,
    input  oStall, oGrant
  );

endinterface

// File: rtl/mem_port_arbiter_priority_sel.sv
// Combinational I/D pick: data is preferred until it has won MAX_D_BURST
// times in a row over a waiting instruction request.
module arb_priority_sel
  import arb_pkg::*;
#(
  parameter int unsigned MAX_D_BURST = 4
) (
  input  logic       i_req_i,
  input  logic       d_req_i,
  input  logic [3:0] streak_i,
  output grant_t     grant_o
);

  // Pick the winning port for this idle cycle.
  always_comb begin
    grant_o = GNT_NONE;
    if (d_req_i && (!i_req_i || (streak_i != 4'(MAX_D_BURST)))) begin
      grant_o = GNT_D;
    end else if (i_req_i) begin
      grant_o = GNT_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction and data
// ports: arbitrate, issue one latched command, wait for read data, pulse ready.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned MAX_D_BURST = 4
) (
  input  logic                iCLK,
  input  logic                iRST,
  mem_port_arbiter_if.slave   bus_io
);

  arb_state_e  state_q, state_d;
  grant_t      grant_q, grant_d;
  logic [3:0]  streak_q, streak_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;
  logic [3:0]  lat_be_q, lat_be_d;
  logic        lat_write_q, lat_write_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic   i_req, d_req;
  grant_t pick;

  assign i_req = is_req(bus_io.iIReadEnable, bus_io.iIWriteEnable);
  assign d_req = is_req(bus_io.iDReadEnable, bus_io.iDWriteEnable);

  arb_priority_sel #(
    .MAX_D_BURST(MAX_D_BURST)
  ) u_sel (
    .i_req_i (i_req),
    .d_req_i (d_req),
    .streak_i(streak_q),
    .grant_o (pick)
  );

  // Next-state: arbitration, command latch, latency count, read-data capture.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    streak_d    = streak_q;
    cnt_d       = cnt_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_be_d    = lat_be_q;
    lat_write_d = lat_write_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (pick == GNT_D) begin
          state_d     = StIssue;
          grant_d     = GNT_D;
          streak_d    = i_req ? (streak_q + 4'd1) : 4'd0;
          lat_addr_d  = bus_io.iDAddress;
          lat_wdata_d = bus_io.iDWriteData;
          lat_be_d    = bus_io.iDByteEnable;
          lat_write_d = bus_io.iDWriteEnable;
        end else if (pick == GNT_I) begin
          state_d     = StIssue;
          grant_d     = GNT_I;
          streak_d    = 4'd0;
          lat_addr_d  = bus_io.iIAddress;
          lat_wdata_d = bus_io.iIWriteData;
          lat_be_d    = bus_io.iIByteEnable;
          lat_write_d = bus_io.iIWriteEnable;
        end
      end
      StIssue: begin
        if (lat_write_q) begin
          state_d = StResp;
        end else begin
          state_d = StWait;
          cnt_d   = 3'd1;
        end
      end
      StWait: begin
        if (cnt_q == 3'(MEM_LATENCY)) begin
          state_d = StResp;
          cnt_d   = 3'd0;
          if (grant_q == GNT_D) begin
            d_rdata_d = bus_io.iMReadData;
          end else begin
            i_rdata_d = bus_io.iMReadData;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StResp: begin
        // Requests are ignored here so the requester can drop its enable.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset; drops any in-flight transaction.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q     <= StIdle;
      grant_q     <= GNT_NONE;
      streak_q    <= 4'd0;
      cnt_q       <= 3'd0;
      lat_addr_q  <= 32'd0;
      lat_wdata_q <= 32'd0;
      lat_be_q    <= 4'd0;
      lat_write_q <= 1'b0;
      i_rdata_q   <= 32'd0;
      d_rdata_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      streak_q    <= streak_d;
      cnt_q       <= cnt_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_be_q    <= lat_be_d;
      lat_write_q <= lat_write_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Outputs: memory strobes only in ISSUE, ready pulses only in RESP.
  always_comb begin
    bus_io.oMReadEnable  = (state_q == StIssue) && !lat_write_q;
    bus_io.oMWriteEnable = (state_q == StIssue) && lat_write_q;
    bus_io.oMByteEnable  = (state_q == StIssue) ? lat_be_q : 4'd0;
    bus_io.oMAddress     = lat_addr_q;
    bus_io.oMWriteData   = lat_wdata_q;
    bus_io.oIReady       = (state_q == StResp) && (grant_q == GNT_I);
    bus_io.oDReady       = (state_q == StResp) && (grant_q == GNT_D);
    bus_io.oIReadData    = i_rdata_q;
    bus_io.oDReadData    = d_rdata_q;
    bus_io.oGrant        = (state_q == StIdle) ? GNT_NONE : grant_q;
    bus_io.oStall        = (i_req && !bus_io.oIReady) || (d_req && !bus_io.oDReady);
  end

endmodule
